// File: rtl/cache_pkg.sv
// Shared widths, address field positions, FSM states and the latched miss record
// for the cache refill path.
`timescale 1ns/1ps
package cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned INDEX_W    = 8;
  localparam int unsigned TAG_W      = 20;
  localparam int unsigned LEN_W      = 8;

  localparam int unsigned LINE_W     = WORD_W * LINE_WORDS;
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS);

  localparam int unsigned TAG_LSB    = 12;
  localparam int unsigned INDEX_LSB  = 4;
  localparam int unsigned OFFSET_LSB = 2;

  localparam logic [LEN_W-1:0] BURST_LEN = LEN_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  // Fields captured from the accepted miss and held for the whole refill
  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               way;
    logic [OFF_W-1:0]   offset;
  } miss_info_t;

  // Line-aligned byte address rebuilt from tag and index
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] index);
    return {tag, index, {INDEX_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/line_assembler.sv
// Collects the read beats of one burst into a line and picks out the
// requested word as it goes past.
`timescale 1ns/1ps
module line_assembler
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              start,
  input  logic              beat_en,
  input  logic [WORD_W-1:0] beat_data,
  input  logic [OFF_W-1:0]  crit_offset,
  output logic [LINE_W-1:0] line,
  output logic              last_beat_c,
  output logic              crit_valid,
  output logic [WORD_W-1:0] crit_data
);

  logic [OFF_W-1:0] beat_cnt;

  assign last_beat_c = (beat_cnt == OFF_W'(LINE_WORDS - 1));

  // Beat counter: restarts on a new miss and again when the burst address is accepted
  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_cnt <= '0;
    end else if (clear || start) begin
      beat_cnt <= '0;
    end else if (beat_en) begin
      beat_cnt <= beat_cnt + OFF_W'(1);
    end
  end

  // Line register: each beat lands in the word slot selected by the counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      line <= '0;
    end else if (clear) begin
      line <= '0;
    end else if (beat_en) begin
      for (int unsigned k = 0; k < LINE_WORDS; k++) begin
        if (beat_cnt == OFF_W'(k)) begin
          line[k*WORD_W +: WORD_W] <= beat_data;
        end
      end
    end
  end

  // Critical word: one-cycle pulse the cycle after the requested beat arrives
  always_ff @(posedge clk) begin
    if (!rstn) begin
      crit_valid <= 1'b0;
      crit_data  <= '0;
    end else begin
      crit_valid <= beat_en && (beat_cnt == crit_offset);
      if (beat_en && (beat_cnt == crit_offset)) begin
        crit_data <= beat_data;
      end
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-refill engine: issues one line-aligned 4-beat read burst per miss,
// assembles the line, forwards the critical word and hands the finished line
// to the write buffer with a one-cycle refill_ready pulse.
`timescale 1ns/1ps
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic [ADDR_W-1:0]  miss_addr,
  input  logic               miss_way,
  output logic               ar_valid,
  input  logic               ar_ready,
  output logic [ADDR_W-1:0]  ar_addr,
  output logic [LEN_W-1:0]   ar_len,
  input  logic               r_valid,
  output logic               r_ready,
  input  logic [WORD_W-1:0]  r_data,
  input  logic               r_last,
  output logic               crit_valid,
  output logic [WORD_W-1:0]  crit_data,
  output logic [LINE_W-1:0]  final_data,
  output logic               refill_ready,
  output logic [INDEX_W-1:0] index,
  output logic [TAG_W-1:0]   tag,
  output logic               way,
  output logic               proto_err
);

  state_t     state_q;
  state_t     state_d;
  miss_info_t info_q;

  logic accept_c;
  logic ar_hs_c;
  logic beat_c;
  logic last_beat_c;
  logic proto_bad_c;

  logic miss_ready_d;
  logic ar_valid_d;
  logic r_ready_d;
  logic refill_ready_d;

  // Byte-within-word bits play no part in a line refill
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^miss_addr[OFFSET_LSB-1:0];

  assign accept_c = miss_valid & miss_ready;
  assign ar_hs_c  = ar_valid & ar_ready;
  assign beat_c   = r_valid & r_ready;

  // r_last must appear on the final beat and nowhere else
  assign proto_bad_c = beat_c && (r_last != last_beat_c);

  assign ar_len = BURST_LEN;
  assign index  = info_q.index;
  assign tag    = info_q.tag;
  assign way    = info_q.way;

  // Next-state and next-output decode; handshake outputs are registered from state_d
  always_comb begin
    state_d        = state_q;
    miss_ready_d   = 1'b0;
    ar_valid_d     = 1'b0;
    r_ready_d      = 1'b0;
    refill_ready_d = 1'b0;

    case (state_q)
      IDLE:    if (accept_c)              state_d = REQ;
      REQ:     if (ar_hs_c)               state_d = RECV;
      RECV:    if (beat_c && last_beat_c) state_d = DONE;
      DONE:                               state_d = IDLE;
      default:                            state_d = IDLE;
    endcase

    miss_ready_d   = (state_d == IDLE);
    ar_valid_d     = (state_d == REQ);
    r_ready_d      = (state_d == RECV);
    refill_ready_d = (state_d == DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake and pulse outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      miss_ready   <= 1'b1;
      ar_valid     <= 1'b0;
      r_ready      <= 1'b0;
      refill_ready <= 1'b0;
    end else begin
      miss_ready   <= miss_ready_d;
      ar_valid     <= ar_valid_d;
      r_ready      <= r_ready_d;
      refill_ready <= refill_ready_d;
    end
  end

  // Miss capture: fields and burst address stay frozen until the next accepted miss
  always_ff @(posedge clk) begin
    if (!rstn) begin
      info_q  <= '0;
      ar_addr <= '0;
    end else if (accept_c) begin
      info_q.tag    <= miss_addr[ADDR_W-1:TAG_LSB];
      info_q.index  <= miss_addr[TAG_LSB-1:INDEX_LSB];
      info_q.way    <= miss_way;
      info_q.offset <= miss_addr[INDEX_LSB-1:OFFSET_LSB];
      ar_addr       <= line_addr(miss_addr[ADDR_W-1:TAG_LSB],
                                 miss_addr[TAG_LSB-1:INDEX_LSB]);
    end
  end

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      proto_err <= 1'b0;
    end else if (proto_bad_c) begin
      proto_err <= 1'b1;
    end
  end

  line_assembler u_line_assembler (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (accept_c),
    .start       (ar_hs_c),
    .beat_en     (beat_c),
    .beat_data   (r_data),
    .crit_offset (info_q.offset),
    .line        (final_data),
    .last_beat_c (last_beat_c),
    .crit_valid  (crit_valid),
    .crit_data   (crit_data)
  );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed table of refills, randomized refills
// against a line-level reference model, and hand sequences for reset and
// back-to-back misses.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rstn;
  logic         miss_valid;
  logic         miss_ready;
  logic [31:0]  miss_addr;
  logic         miss_way;
  logic         ar_valid;
  logic         ar_ready;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic         r_valid;
  logic         r_ready;
  logic [31:0]  r_data;
  logic         r_last;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic [127:0] final_data;
  logic         refill_ready;
  logic [7:0]   index;
  logic [19:0]  tag;
  logic         way;
  logic         proto_err;

  cache_refill_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .miss_valid   (miss_valid),
    .miss_ready   (miss_ready),
    .miss_addr    (miss_addr),
    .miss_way     (miss_way),
    .ar_valid     (ar_valid),
    .ar_ready     (ar_ready),
    .ar_addr      (ar_addr),
    .ar_len       (ar_len),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_data       (r_data),
    .r_last       (r_last),
    .crit_valid   (crit_valid),
    .crit_data    (crit_data),
    .final_data   (final_data),
    .refill_ready (refill_ready),
    .index        (index),
    .tag          (tag),
    .way          (way),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic         way;
    logic [31:0]  beat [4];
    logic [3:0]   lastm;
    int           stall;
    bit           gap;
    logic [127:0] exp_line;
    logic [7:0]   exp_index;
    logic [19:0]  exp_tag;
    logic [31:0]  exp_crit;
    bit           exp_proto;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  int          hs_cnt = 0;
  int          rf_cnt = 0;
  int          rf_cyc = 0;
  int          cr_cnt = 0;
  int          cr_cyc = 0;
  logic [31:0] cr_data = '0;
  bit          model_proto = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (ar_valid && ar_ready) hs_cnt <= hs_cnt + 1;
    if (refill_ready) begin
      rf_cnt <= rf_cnt + 1;
      rf_cyc <= cyc;
    end
    if (crit_valid) begin
      cr_cnt  <= cr_cnt + 1;
      cr_cyc  <= cyc;
      cr_data <= crit_data;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic w,
                              input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [31:0] b3,
                              input logic [3:0] lm, input int st, input bit g,
                              input logic [127:0] el, input logic [7:0] ei,
                              input logic [19:0] et, input logic [31:0] ec,
                              input bit ep);
    vec_t v;
    v.addr = a; v.way = w;
    v.beat[0] = b0; v.beat[1] = b1; v.beat[2] = b2; v.beat[3] = b3;
    v.lastm = lm; v.stall = st; v.gap = g;
    v.exp_line = el; v.exp_index = ei; v.exp_tag = et; v.exp_crit = ec;
    v.exp_proto = ep;
    return v;
  endfunction

  // Reference model: a refill returns the 4 beats in order as one line, the
  // requested word is beat number (addr/4)%4, index=(addr/16)%256, tag=addr/4096
  function automatic vec_t model_vec(input logic [31:0] a, input logic w,
                                     input int st, input bit g, input bit prior_err);
    vec_t v;
    v.addr = a; v.way = w; v.stall = st; v.gap = g;
    v.lastm = 4'b1000;
    v.exp_line = '0;
    for (int k = 0; k < 4; k++) begin
      v.beat[k] = $urandom;
      v.exp_line[32*k +: 32] = v.beat[k];
    end
    v.exp_index = 8'((a >> 4) & 32'hFF);
    v.exp_tag   = 20'(a >> 12);
    v.exp_crit  = v.beat[(a >> 2) & 32'h3];
    v.exp_proto = prior_err;
    return v;
  endfunction

  task automatic chk_reset(input string nm);
    chk({nm, "_ctrl"}, {122'b0, ar_valid, r_ready, crit_valid, refill_ready, proto_err, way}, '0);
    chk({nm, "_fields"}, {36'b0, index, tag, ar_addr, crit_data}, '0);
    chk({nm, "_final_data"}, final_data, '0);
    chk({nm, "_miss_ready"}, miss_ready, 1);
    chk({nm, "_ar_len"}, ar_len, 3);
  endtask

  // Drive one complete refill and check it against the vector's expectations
  task automatic do_refill(input vec_t v, input bit b2b, input bit hold_next,
                           input logic [31:0] nxt_addr, input logic nxt_way);
    int          c0, cb, hs0, rf0, cr0, wait_n, prev_rf;
    logic [31:0] exp_ar;
    exp_ar  = v.addr & 32'hFFFF_FFF0;
    wait_n  = 0;
    cb      = -100;
    prev_rf = rf_cyc;
    while (!miss_ready && wait_n < 50) begin
      tick();
      wait_n++;
    end
    chk("miss_ready_idle", miss_ready, 1);
    if (b2b) chk("b2b_accept_cycle", cyc, prev_rf + 1);
    miss_valid = 1'b1; miss_addr = v.addr; miss_way = v.way;
    c0 = cyc; hs0 = hs_cnt; rf0 = rf_cnt; cr0 = cr_cnt;
    tick();
    miss_valid = 1'b0;
    chk("ar_valid", ar_valid, 1);
    chk("ar_addr", ar_addr, exp_ar);
    chk("ar_len", ar_len, 3);
    chk("miss_ready_req", miss_ready, 0);
    ar_ready = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      chk("ar_stall_stable", {ar_valid, ar_addr}, {1'b1, exp_ar});
      tick();
    end
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    chk("ar_handshakes", hs_cnt - hs0, 1);
    chk("ar_valid_drop", ar_valid, 0);
    for (int k = 0; k < 4; k++) begin
      if (v.gap) begin
        r_valid = 1'b0;
        miss_valid = 1'b1; miss_addr = 32'hFFFF_FFF0;
        chk("miss_ready_busy", miss_ready, 0);
        tick();
        miss_valid = 1'b0; miss_addr = v.addr;
      end
      chk("r_ready", r_ready, 1);
      r_valid = 1'b1; r_data = v.beat[k]; r_last = v.lastm[k];
      if (k == int'(v.addr[3:2])) cb = cyc;
      tick();
    end
    r_valid = 1'b0; r_last = 1'b0;
    chk("refill_ready", refill_ready, 1);
    chk("final_data", final_data, v.exp_line);
    chk("index", index, v.exp_index);
    chk("tag", tag, v.exp_tag);
    chk("way", way, v.way);
    chk("proto_err", proto_err, v.exp_proto);
    if (hold_next) begin
      miss_valid = 1'b1; miss_addr = nxt_addr; miss_way = nxt_way;
      chk("miss_ready_done", miss_ready, 0);
    end
    tick();
    chk("refill_pulse_width", refill_ready, 0);
    chk("refill_count", rf_cnt - rf0, 1);
    chk("refill_latency", rf_cyc - c0, 6 + v.stall + 4 * int'(v.gap));
    chk("crit_count", cr_cnt - cr0, 1);
    chk("crit_data", cr_data, v.exp_crit);
    chk("crit_latency", cr_cyc - cb, 1);
    chk("hold_final_data", final_data, v.exp_line);
  endtask

  vec_t tbl [5];
  vec_t v1, v2;
  int   rf_snap;

  initial begin
    rstn = 1'b0; miss_valid = 1'b0; miss_addr = '0; miss_way = 1'b0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;

    tbl[0] = mk(32'h1234_5678, 1'b1, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b1000, 0, 1'b0,
                128'h000000A3_000000A2_000000A1_000000A0, 8'h67, 20'h12345, 32'hA2, 1'b0);
    tbl[1] = mk(32'hDEAD_BEEC, 1'b0, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 4'b1000, 5, 1'b0,
                128'h000000B3_000000B2_000000B1_000000B0, 8'hEE, 20'hDEADB, 32'hB3, 1'b0);
    tbl[2] = mk(32'h0000_0004, 1'b1, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 4'b1000, 0, 1'b1,
                128'h000000C3_000000C2_000000C1_000000C0, 8'h00, 20'h00000, 32'hC1, 1'b0);
    tbl[3] = mk(32'h8000_0010, 1'b0, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 4'b1010, 0, 1'b0,
                128'h000000D3_000000D2_000000D1_000000D0, 8'h01, 20'h80000, 32'hD0, 1'b1);
    tbl[4] = mk(32'h0000_0FFC, 1'b1, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 4'b0000, 2, 1'b1,
                128'h000000E3_000000E2_000000E1_000000E0, 8'hFF, 20'h00000, 32'hE3, 1'b1);

    repeat (3) tick();
    chk_reset("reset");
    rstn = 1'b1;
    tick();

    // Directed table: basic, address stall, beat gaps, protocol errors
    for (int i = 0; i < 5; i++) do_refill(tbl[i], 1'b0, 1'b0, '0, 1'b0);
    chk("proto_err_sticky", proto_err, 1);

    // Reset in the middle of a burst, after beat 2
    miss_valid = 1'b1; miss_addr = 32'h0ABC_DEF8; miss_way = 1'b1;
    tick();
    miss_valid = 1'b0; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r_valid = 1'b1; r_data = 32'h5500 + 32'(k); r_last = 1'b0;
      tick();
    end
    r_valid = 1'b0;
    rf_snap = rf_cnt;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk_reset("midburst_reset");
    repeat (4) tick();
    chk("midburst_no_refill", rf_cnt - rf_snap, 0);
    model_proto = 1'b0;
    do_refill(model_vec(32'h0ABC_DEF8, 1'b1, 0, 1'b0, model_proto), 1'b0, 1'b0, '0, 1'b0);

    // Randomized refills against the reference model
    for (int i = 0; i < 16; i++) begin
      do_refill(model_vec($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), model_proto), 1'b0, 1'b0, '0, 1'b0);
    end

    // Back-to-back misses: second request held from the DONE cycle
    v1 = model_vec(32'h7654_3218, 1'b0, 0, 1'b0, model_proto);
    v2 = model_vec(32'h0F0F_0A34, 1'b1, 1, 1'b0, model_proto);
    do_refill(v1, 1'b0, 1'b1, v2.addr, v2.way);
    do_refill(v2, 1'b1, 1'b0, '0, 1'b0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
